// File: rtl/cache_pkg.sv
// Shared types and constants for the 4-line fully-associative read cache.
// The line record is sized by LINE_TAG_W/LINE_DATA_W, which the top's TAG_W/DATA_W default to.
package cache_pkg;

    localparam int NUM_LINES   = 4;
    localparam int IDX_W       = 2;
    localparam int AGE_W       = 2;
    localparam int LINE_TAG_W  = 8;
    localparam int LINE_DATA_W = 8;

    localparam logic [AGE_W-1:0] AGE_MAX = 2'd3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOOKUP    = 2'd1,
        MISS_WAIT = 2'd2,
        RESP      = 2'd3
    } state_t;

    typedef struct packed {
        logic                   valid;
        logic [LINE_TAG_W-1:0]  tag;
        logic [LINE_DATA_W-1:0] data;
        logic [AGE_W-1:0]       age;
    } line_t;

    // Lowest-index line whose valid bit is clear; 0 when every line is valid.
    function automatic logic [IDX_W-1:0] first_free(input logic [NUM_LINES-1:0] valid);
        logic [IDX_W-1:0] idx;
        idx = {IDX_W{1'b0}};
        for (int i = NUM_LINES - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                idx = IDX_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/lru_victim_sel.sv
// Victim choice (lowest free line, else the age-3 line) and true-LRU age update
// for whichever line is touched: the hit line, or the victim on a fill.
module lru_victim_sel
    import cache_pkg::*;
(
    input  logic [NUM_LINES-1:0]            valid,
    input  logic [NUM_LINES-1:0][AGE_W-1:0] ages,
    input  logic                            hit,
    input  logic [IDX_W-1:0]                hit_idx,
    output logic [IDX_W-1:0]                victim_idx,
    output logic [NUM_LINES-1:0][AGE_W-1:0] next_ages
);

    logic [IDX_W-1:0] touch_idx_s;
    logic [AGE_W-1:0] old_age_s;

    // Victim selection
    always_comb begin
        victim_idx = {IDX_W{1'b0}};
        if (~&valid) begin
            victim_idx = first_free(valid);
        end else begin
            for (int i = NUM_LINES - 1; i >= 0; i--) begin
                victim_idx = (ages[i] == AGE_MAX) ? IDX_W'(i) : victim_idx;
            end
        end
    end

    // Age update; a free line being filled behaves as if its old age were the maximum
    always_comb begin
        touch_idx_s = hit ? hit_idx : victim_idx;
        old_age_s   = valid[touch_idx_s] ? ages[touch_idx_s] : AGE_MAX;
        next_ages   = ages;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (IDX_W'(i) == touch_idx_s) begin
                next_ages[i] = {AGE_W{1'b0}};
            end else if (valid[i] && (ages[i] < old_age_s)) begin
                next_ages[i] = ages[i] + 2'd1;
            end else begin
                next_ages[i] = ages[i];
            end
        end
    end

endmodule

// File: rtl/lectura_lineas_cache.sv
// Read-only 4-line fully-associative cache: lookup, miss fill from backing memory,
// one-cycle response strobe, true-LRU replacement.
module lectura_lineas_cache
    import cache_pkg::*;
#(
    parameter int TAG_W  = LINE_TAG_W,
    parameter int DATA_W = LINE_DATA_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [TAG_W-1:0]     req_tag,
    output logic                 rsp_valid,
    output logic                 rsp_hit,
    output logic [DATA_W-1:0]    rsp_data,
    output logic                 mem_req,
    output logic [TAG_W-1:0]     mem_tag,
    input  logic                 mem_ack,
    input  logic [DATA_W-1:0]    mem_data,
    output logic [NUM_LINES-1:0] line_valid
);

    state_t                          state_r;
    line_t                           lines_r [NUM_LINES];
    logic [TAG_W-1:0]                tag_r;
    logic [NUM_LINES-1:0]            valid_s;
    logic [NUM_LINES-1:0][AGE_W-1:0] ages_s;
    logic [NUM_LINES-1:0][AGE_W-1:0] next_ages_s;
    logic                            hit_s;
    logic [IDX_W-1:0]                hit_idx_s;
    logic [IDX_W-1:0]                victim_idx_s;

    // Tag match against the registered tag; scanning downward lets the lowest index win
    always_comb begin
        valid_s   = {NUM_LINES{1'b0}};
        ages_s    = {(NUM_LINES * AGE_W){1'b0}};
        hit_s     = 1'b0;
        hit_idx_s = {IDX_W{1'b0}};
        for (int i = NUM_LINES - 1; i >= 0; i--) begin
            valid_s[i] = lines_r[i].valid;
            ages_s[i]  = lines_r[i].age;
            if (lines_r[i].valid && (lines_r[i].tag == tag_r)) begin
                hit_s     = 1'b1;
                hit_idx_s = IDX_W'(i);
            end else begin
                hit_s     = hit_s;
                hit_idx_s = hit_idx_s;
            end
        end
    end

    assign line_valid = valid_s;

    lru_victim_sel u_lru (
        .valid      (valid_s),
        .ages       (ages_s),
        .hit        (hit_s),
        .hit_idx    (hit_idx_s),
        .victim_idx (victim_idx_s),
        .next_ages  (next_ages_s)
    );

    // Request FSM, line storage and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            tag_r     <= {TAG_W{1'b0}};
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_hit   <= 1'b0;
            rsp_data  <= {DATA_W{1'b0}};
            mem_req   <= 1'b0;
            mem_tag   <= {TAG_W{1'b0}};
            for (int i = 0; i < NUM_LINES; i++) begin
                lines_r[i].valid <= 1'b0;
                lines_r[i].tag   <= {LINE_TAG_W{1'b0}};
                lines_r[i].data  <= {LINE_DATA_W{1'b0}};
                lines_r[i].age   <= {AGE_W{1'b0}};
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        tag_r     <= req_tag;
                        req_ready <= 1'b0;
                        state_r   <= LOOKUP;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                LOOKUP: begin
                    if (hit_s) begin
                        rsp_valid <= 1'b1;
                        rsp_hit   <= 1'b1;
                        rsp_data  <= lines_r[hit_idx_s].data;
                        for (int i = 0; i < NUM_LINES; i++) begin
                            lines_r[i].age <= next_ages_s[i];
                        end
                        state_r <= RESP;
                    end else begin
                        mem_req <= 1'b1;
                        mem_tag <= tag_r;
                        state_r <= MISS_WAIT;
                    end
                end
                MISS_WAIT: begin
                    if (mem_ack) begin
                        lines_r[victim_idx_s].valid <= 1'b1;
                        lines_r[victim_idx_s].tag   <= tag_r;
                        lines_r[victim_idx_s].data  <= mem_data;
                        for (int i = 0; i < NUM_LINES; i++) begin
                            lines_r[i].age <= next_ages_s[i];
                        end
                        mem_req   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_hit   <= 1'b0;
                        rsp_data  <= mem_data;
                        state_r   <= RESP;
                    end else begin
                        mem_req <= 1'b1;
                    end
                end
                RESP: begin
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                    state_r   <= IDLE;
                end
                default: begin
                    rsp_valid <= 1'b0;
                    mem_req   <= 1'b0;
                    req_ready <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lectura_lineas_cache.sv
// Self-checking bench: directed vector table, hand sequences for reset/back-to-back
// corners, and random reads against an MRU-list reference model.
module tb_lectura_lineas_cache;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_tag = 8'h00;
    logic       rsp_valid;
    logic       rsp_hit;
    logic [7:0] rsp_data;
    logic       mem_req;
    logic [7:0] mem_tag;
    logic       mem_ack = 1'b0;
    logic [7:0] mem_data = 8'h00;
    logic [3:0] line_valid;

    int n_total = 0;
    int n_pass  = 0;

    lectura_lineas_cache #(.TAG_W(8), .DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_tag    (req_tag),
        .rsp_valid  (rsp_valid),
        .rsp_hit    (rsp_hit),
        .rsp_data   (rsp_data),
        .mem_req    (mem_req),
        .mem_tag    (mem_tag),
        .mem_ack    (mem_ack),
        .mem_data   (mem_data),
        .line_valid (line_valid)
    );

    always #5 clk = ~clk;

    // Reference model: line contents plus a recency list of line indices (front = most recent)
    logic       m_valid [4];
    logic [7:0] m_tag   [4];
    logic [7:0] m_data  [4];
    int         lru_q   [$];

    function automatic void model_clear();
        for (int i = 0; i < 4; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 8'h00;
            m_data[i]  = 8'h00;
        end
        lru_q.delete();
    endfunction

    function automatic void model_access(input logic [7:0] tag, input logic [7:0] fill,
                                         output bit hit, output logic [7:0] data);
        int k = -1;
        for (int i = 0; i < 4; i++)
            if (k < 0 && m_valid[i] && m_tag[i] == tag) k = i;
        if (k >= 0) begin
            hit  = 1'b1;
            data = m_data[k];
        end else begin
            hit = 1'b0;
            for (int i = 0; i < 4; i++)
                if (k < 0 && !m_valid[i]) k = i;
            if (k < 0) k = lru_q[lru_q.size() - 1];
            m_valid[k] = 1'b1;
            m_tag[k]   = tag;
            m_data[k]  = fill;
            data       = fill;
        end
        for (int j = 0; j < lru_q.size(); j++)
            if (lru_q[j] == k) begin
                lru_q.delete(j);
                break;
            end
        lru_q.push_front(k);
    endfunction

    function automatic logic [3:0] model_lv();
        return {m_valid[3], m_valid[2], m_valid[1], m_valid[0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = 1'b0;
        mem_ack   = 1'b0;
        tick();
        tick();
        chk("rst_req_ready",  32'(req_ready),  32'd0);
        chk("rst_rsp_valid",  32'(rsp_valid),  32'd0);
        chk("rst_rsp_hit",    32'(rsp_hit),    32'd0);
        chk("rst_rsp_data",   32'(rsp_data),   32'd0);
        chk("rst_mem_req",    32'(mem_req),    32'd0);
        chk("rst_mem_tag",    32'(mem_tag),    32'd0);
        chk("rst_line_valid", 32'(line_valid), 32'd0);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", 32'(req_ready), 32'd1);
        model_clear();
    endtask

    // One read transaction; miss fills are acked in the delay-th MISS_WAIT cycle
    task automatic do_read(input logic [7:0] tag, input int delay, input logic [7:0] fill,
                           output bit obs_hit, output logic [7:0] obs_data, output logic [3:0] obs_lv);
        bit         e_hit;
        logic [7:0] e_data;
        int         n = 0;
        int         req_cnt = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("accept_wait", 32'(n < 20), 32'd1);
        req_valid = 1'b1;
        req_tag   = tag;
        tick();
        req_valid = 1'b0;
        model_access(tag, fill, e_hit, e_data);
        chk("lookup_ready",   32'(req_ready), 32'd0);
        chk("lookup_rsp",     32'(rsp_valid), 32'd0);
        chk("lookup_mem_req", 32'(mem_req),   32'd0);
        tick();
        if (!e_hit) begin
            for (int d = 1; d <= delay; d++) begin
                if (mem_req === 1'b1 && mem_tag === tag) req_cnt++;
                if (d == delay) begin
                    mem_ack  = 1'b1;
                    mem_data = fill;
                end
                tick();
                mem_ack  = 1'b0;
                mem_data = 8'($urandom);
            end
            chk("mem_req_cycles", 32'(req_cnt), 32'(delay));
        end
        chk("rsp_valid",      32'(rsp_valid),  32'd1);
        chk("rsp_hit",        32'(rsp_hit),    32'(e_hit));
        chk("rsp_data",       32'(rsp_data),   32'(e_data));
        chk("rsp_mem_req",    32'(mem_req),    32'd0);
        chk("rsp_line_valid", 32'(line_valid), 32'(model_lv()));
        obs_hit  = rsp_hit;
        obs_data = rsp_data;
        obs_lv   = line_valid;
        tick();
        chk("rsp_one_cycle", 32'(rsp_valid), 32'd0);
    endtask

    typedef struct {
        bit         rst_before;
        logic [7:0] tag;
        int         delay;
        logic [7:0] fill;
        bit         exp_hit;
        logic [7:0] exp_data;
        logic [3:0] exp_lv;
    } vec_t;

    vec_t vecs [19];

    initial begin
        bit         o_hit;
        logic [7:0] o_data;
        logic [3:0] o_lv;
        bit         e_hit;
        logic [7:0] e_data;

        vecs[0]  = '{1'b1, 8'h12, 3, 8'hA5, 1'b0, 8'hA5, 4'b0001};
        vecs[1]  = '{1'b0, 8'h12, 1, 8'h00, 1'b1, 8'hA5, 4'b0001};
        vecs[2]  = '{1'b1, 8'h01, 2, 8'h11, 1'b0, 8'h11, 4'b0001};
        vecs[3]  = '{1'b0, 8'h02, 1, 8'h22, 1'b0, 8'h22, 4'b0011};
        vecs[4]  = '{1'b0, 8'h03, 2, 8'h33, 1'b0, 8'h33, 4'b0111};
        vecs[5]  = '{1'b0, 8'h04, 1, 8'h44, 1'b0, 8'h44, 4'b1111};
        vecs[6]  = '{1'b0, 8'h01, 1, 8'h00, 1'b1, 8'h11, 4'b1111};
        vecs[7]  = '{1'b0, 8'h05, 2, 8'h55, 1'b0, 8'h55, 4'b1111};
        vecs[8]  = '{1'b0, 8'h01, 1, 8'h00, 1'b1, 8'h11, 4'b1111};
        vecs[9]  = '{1'b0, 8'h03, 1, 8'h00, 1'b1, 8'h33, 4'b1111};
        vecs[10] = '{1'b0, 8'h04, 1, 8'h00, 1'b1, 8'h44, 4'b1111};
        vecs[11] = '{1'b0, 8'h05, 1, 8'h00, 1'b1, 8'h55, 4'b1111};
        vecs[12] = '{1'b0, 8'h02, 1, 8'h66, 1'b0, 8'h66, 4'b1111};
        vecs[13] = '{1'b0, 8'h01, 1, 8'h77, 1'b0, 8'h77, 4'b1111};
        vecs[14] = '{1'b1, 8'hA1, 1, 8'hA1, 1'b0, 8'hA1, 4'b0001};
        vecs[15] = '{1'b0, 8'hA2, 1, 8'hA2, 1'b0, 8'hA2, 4'b0011};
        vecs[16] = '{1'b0, 8'hA3, 1, 8'hA3, 1'b0, 8'hA3, 4'b0111};
        vecs[17] = '{1'b1, 8'hB1, 1, 8'hB1, 1'b0, 8'hB1, 4'b0001};
        vecs[18] = '{1'b0, 8'hB2, 1, 8'hB2, 1'b0, 8'hB2, 4'b0011};

        model_clear();
        for (int v = 0; v < 19; v++) begin
            if (vecs[v].rst_before) do_reset();
            do_read(vecs[v].tag, vecs[v].delay, vecs[v].fill, o_hit, o_data, o_lv);
            chk($sformatf("vec%0d_hit", v),  32'(o_hit),  32'(vecs[v].exp_hit));
            chk($sformatf("vec%0d_data", v), 32'(o_data), 32'(vecs[v].exp_data));
            chk($sformatf("vec%0d_lv", v),   32'(o_lv),   32'(vecs[v].exp_lv));
        end

        // Reset while waiting on a fill, with a coincident ack, then a stray ack in IDLE
        do_reset();
        req_valid = 1'b1;
        req_tag   = 8'h3C;
        tick();
        req_valid = 1'b0;
        tick();
        chk("mw_mem_req", 32'(mem_req), 32'd1);
        chk("mw_mem_tag", 32'(mem_tag), 32'h3C);
        tick();
        rst      = 1'b1;
        mem_ack  = 1'b1;
        mem_data = 8'h77;
        tick();
        chk("abort_mem_req",    32'(mem_req),    32'd0);
        chk("abort_line_valid", 32'(line_valid), 32'd0);
        chk("abort_rsp_valid",  32'(rsp_valid),  32'd0);
        rst     = 1'b0;
        mem_ack = 1'b0;
        tick();
        tick();
        mem_ack  = 1'b1;
        mem_data = 8'h99;
        tick();
        mem_ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("stray_rsp_valid",  32'(rsp_valid),  32'd0);
            chk("stray_mem_req",    32'(mem_req),    32'd0);
            chk("stray_line_valid", 32'(line_valid), 32'd0);
            tick();
        end
        model_clear();
        do_read(8'h3C, 2, 8'h5A, o_hit, o_data, o_lv);
        chk("after_abort_miss", 32'(o_hit), 32'd0);

        // req_valid held high on a hitting tag: acceptance every third cycle
        do_reset();
        do_read(8'h40, 1, 8'hC3, o_hit, o_data, o_lv);
        req_valid = 1'b1;
        req_tag   = 8'h40;
        for (int c = 0; c < 12; c++) begin
            chk("b2b_ready",     32'(req_ready), 32'(c % 3 == 0));
            chk("b2b_rsp_valid", 32'(rsp_valid), 32'(c % 3 == 2));
            if (c % 3 == 2) begin
                model_access(8'h40, 8'h00, e_hit, e_data);
                chk("b2b_hit",  32'(rsp_hit),  32'(e_hit));
                chk("b2b_data", 32'(rsp_data), 32'(e_data));
                chk("b2b_mem_req", 32'(mem_req), 32'd0);
            end
            tick();
        end
        req_valid = 1'b0;

        // Random reads over a small tag set so hits, fills and evictions all occur
        do_reset();
        for (int t = 0; t < 80; t++) begin
            if ($urandom_range(0, 24) == 0) do_reset();
            do_read(8'($urandom_range(0, 6)), int'($urandom_range(1, 4)), 8'($urandom),
                    o_hit, o_data, o_lv);
            if ($urandom_range(0, 2) == 0) tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
